// File: rtl/score_keeper.sv
// score_keeper: BCD scoring, lives, fright timer and INIT/PLAY/WIN/LOSE game FSM
module score_keeper #(
  parameter logic [15:0] PELLET_PTS    = 16'h0010,
  parameter logic [15:0] POWER_PTS     = 16'h0050,
  parameter logic [15:0] GHOST_PTS     = 16'h0200,
  parameter int          PELLET_TOTAL  = 240,
  parameter int          LIVES_INIT    = 3,
  parameter logic [31:0] FRIGHT_CYCLES = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic        pelletEaten,
  input  logic        powerEaten,
  input  logic        ghostHit,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        frightened,
  output logic        respawn,
  output logic        win,
  output logic        lose,
  output logic [1:0]  state
);
  localparam logic [1:0] INIT = 2'b00;
  localparam logic [1:0] PLAY = 2'b01;
  localparam logic [1:0] WIN  = 2'b10;
  localparam logic [1:0] LOSE = 2'b11;
  // at least two bits so a double-eat count of 2 is representable
  localparam int PW = PELLET_TOTAL < 3 ? 2 : $clog2(PELLET_TOTAL + 1);
  localparam logic [PW-1:0] PL_INIT = PW'(PELLET_TOTAL);
  localparam logic [1:0]    LV_INIT = 2'(LIVES_INIT);

  logic [1:0]    state_q, state_d;
  logic [15:0]   score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [PW-1:0] pl_q, pl_d;
  logic [31:0]   timer_q, timer_d;
  logic          respawn_q, respawn_d;

  logic [16:0]   add1, add2, add3;
  logic [15:0]   sc_play;
  logic [1:0]    eaten;
  logic [PW-1:0] pl_play;
  logic [31:0]   tm_play;
  logic [1:0]    lv_hit;
  logic          fr, won, hit;

  // four-digit BCD add; bit 16 is the carry out of the thousands digit
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      c = s > 5'd9;
      s = c ? s + 5'd6 : s;
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // PLAY-cycle datapath: scoring with saturation, pellet floor, timer, hit decode
  always_comb begin
    fr      = timer_q != 32'd0;
    add1    = bcd_add(score_q, pelletEaten ? PELLET_PTS : 16'h0000);
    add2    = bcd_add(add1[15:0], powerEaten ? POWER_PTS : 16'h0000);
    add3    = bcd_add(add2[15:0], (ghostHit && fr) ? GHOST_PTS : 16'h0000);
    sc_play = (add1[16] | add2[16] | add3[16]) ? 16'h9999 : add3[15:0];
    eaten   = {1'b0, pelletEaten} + {1'b0, powerEaten};
    pl_play = pl_q > PW'(eaten) ? pl_q - PW'(eaten) : '0;
    tm_play = powerEaten ? FRIGHT_CYCLES : (fr ? timer_q - 32'd1 : 32'd0);
    won     = pl_play == '0;
    hit     = ghostHit && !fr && !won;
    lv_hit  = lives_q - 2'd1;
  end

  // game FSM and next-state of every register
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    pl_d      = pl_q;
    timer_d   = timer_q;
    respawn_d = 1'b0;
    case (state_q)
      INIT: if (start) begin
        state_d = PLAY;
        score_d = 16'h0000;
        lives_d = LV_INIT;
        pl_d    = PL_INIT;
        timer_d = 32'd0;
      end
      PLAY: begin
        score_d = sc_play;
        pl_d    = pl_play;
        timer_d = tm_play;
        if (won) begin
          state_d = WIN;
          timer_d = 32'd0;
        end else if (hit) begin
          lives_d   = lv_hit;
          timer_d   = 32'd0;
          state_d   = lv_hit == 2'd0 ? LOSE : PLAY;
          respawn_d = lv_hit != 2'd0;
        end
      end
      default: begin
        timer_d = 32'd0;
        state_d = ack ? INIT : state_q;
      end
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= INIT;
      score_q   <= 16'h0000;
      lives_q   <= LV_INIT;
      pl_q      <= PL_INIT;
      timer_q   <= 32'd0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      pl_q      <= pl_d;
      timer_q   <= timer_d;
      respawn_q <= respawn_d;
    end
  end

  assign score      = score_q;
  assign lives      = lives_q;
  assign frightened = timer_q != 32'd0;
  assign respawn    = respawn_q;
  assign win        = state_q == WIN;
  assign lose       = state_q == LOSE;
  assign state      = state_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper with two parameter sets
module tb_score_keeper;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_start = 0, a_ack = 0, a_pe = 0, a_pw = 0, a_gh = 0;
  logic b_start = 0, b_ack = 0, b_pe = 0, b_pw = 0, b_gh = 0;
  logic [15:0] a_score, b_score;
  logic [1:0]  a_lives, b_lives, a_state, b_state;
  logic        a_fr, a_rs, a_win, a_lose, b_fr, b_rs, b_win, b_lose;

  logic [24:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_keeper #(.PELLET_TOTAL(4), .FRIGHT_CYCLES(32'd8), .LIVES_INIT(3)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .ack(a_ack),
    .pelletEaten(a_pe), .powerEaten(a_pw), .ghostHit(a_gh),
    .score(a_score), .lives(a_lives), .frightened(a_fr), .respawn(a_rs),
    .win(a_win), .lose(a_lose), .state(a_state));

  score_keeper #(.PELLET_PTS(16'h0045), .POWER_PTS(16'h0050), .GHOST_PTS(16'h9000),
                 .PELLET_TOTAL(100), .FRIGHT_CYCLES(32'd8), .LIVES_INIT(3)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .ack(b_ack),
    .pelletEaten(b_pe), .powerEaten(b_pw), .ghostHit(b_gh),
    .score(b_score), .lives(b_lives), .frightened(b_fr), .respawn(b_rs),
    .win(b_win), .lose(b_lose), .state(b_state));

  function automatic logic [23:0] pk(input logic [1:0] st, input logic [1:0] lv,
                                     input logic [15:0] sc, input logic fr, input logic rs);
    return {st, st == 2'd2, st == 2'd3, rs, fr, lv, sc};
  endfunction

  task automatic step(input bit sel, input bit rst, input bit st, input bit ak,
                      input bit pe, input bit pw, input bit gh, input logic [23:0] e);
    @(negedge clk);
    reset = rst;
    {a_start, a_ack, a_pe, a_pw, a_gh} = sel ? 5'b0 : {st, ak, pe, pw, gh};
    {b_start, b_ack, b_pe, b_pw, b_gh} = sel ? {st, ak, pe, pw, gh} : 5'b0;
    exp_q.push_back({sel, e});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [24:0] ent;
        logic [23:0] act;
        ent = exp_q.pop_front();
        act = ent[24] ? {b_state, b_win, b_lose, b_rs, b_fr, b_lives, b_score}
                      : {a_state, a_win, a_lose, a_rs, a_fr, a_lives, a_score};
        n_vec++;
        if (act !== ent[23:0]) begin
          n_bad++;
          $display("FAIL vec%0d dut%0d: got st=%h win=%b lose=%b rs=%b fr=%b lv=%0d sc=%h, need st=%h win=%b lose=%b rs=%b fr=%b lv=%0d sc=%h",
                   n_vec, ent[24], act[23:22], act[21], act[20], act[19], act[18], act[17:16], act[15:0],
                   ent[23:22], ent[21], ent[20], ent[19], ent[18], ent[17:16], ent[15:0]);
        end
      end
    end
  end

  initial begin
    // reset, INIT ignores events
    step(0, 0, 0, 0, 0, 0, 0, pk(0, 3, 16'h0000, 0, 0));
    step(1, 0, 0, 0, 0, 0, 0, pk(0, 3, 16'h0000, 0, 0));
    step(0, 1, 0, 0, 1, 0, 0, pk(0, 3, 16'h0000, 0, 0));
    step(0, 1, 0, 1, 0, 0, 0, pk(0, 3, 16'h0000, 0, 0));
    // game 1: pellets then three unfrightened hits -> LOSE
    step(0, 1, 1, 0, 0, 0, 0, pk(1, 3, 16'h0000, 0, 0));
    step(0, 1, 0, 0, 1, 0, 0, pk(1, 3, 16'h0010, 0, 0));
    step(0, 1, 0, 0, 1, 0, 0, pk(1, 3, 16'h0020, 0, 0));
    step(0, 1, 0, 0, 1, 0, 0, pk(1, 3, 16'h0030, 0, 0));
    step(0, 1, 1, 0, 0, 0, 0, pk(1, 3, 16'h0030, 0, 0));
    step(0, 1, 0, 0, 0, 0, 1, pk(1, 2, 16'h0030, 0, 1));
    step(0, 1, 0, 0, 0, 0, 0, pk(1, 2, 16'h0030, 0, 0));
    step(0, 1, 0, 0, 0, 0, 1, pk(1, 1, 16'h0030, 0, 1));
    step(0, 1, 0, 0, 0, 0, 1, pk(3, 0, 16'h0030, 0, 0));
    step(0, 1, 0, 0, 1, 0, 0, pk(3, 0, 16'h0030, 0, 0));
    step(0, 1, 1, 0, 0, 0, 0, pk(3, 0, 16'h0030, 0, 0));
    step(0, 1, 0, 1, 0, 0, 0, pk(0, 0, 16'h0030, 0, 0));
    // game 2: power pellet, 8-cycle fright window with a ghost eaten, then WIN
    step(0, 1, 1, 0, 0, 0, 0, pk(1, 3, 16'h0000, 0, 0));
    step(0, 1, 0, 0, 0, 1, 0, pk(1, 3, 16'h0050, 1, 0));
    step(0, 1, 0, 0, 0, 0, 0, pk(1, 3, 16'h0050, 1, 0));
    step(0, 1, 0, 0, 0, 0, 0, pk(1, 3, 16'h0050, 1, 0));
    step(0, 1, 0, 0, 0, 0, 1, pk(1, 3, 16'h0250, 1, 0));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, pk(1, 3, 16'h0250, 1, 0));
    step(0, 1, 0, 0, 0, 0, 0, pk(1, 3, 16'h0250, 0, 0));
    step(0, 1, 0, 0, 1, 0, 0, pk(1, 3, 16'h0260, 0, 0));
    step(0, 1, 0, 0, 1, 0, 0, pk(1, 3, 16'h0270, 0, 0));
    step(0, 1, 0, 0, 1, 0, 1, pk(2, 3, 16'h0280, 0, 0));
    step(0, 1, 1, 0, 0, 0, 0, pk(2, 3, 16'h0280, 0, 0));
    step(0, 1, 0, 1, 0, 0, 0, pk(0, 3, 16'h0280, 0, 0));
    // game 3: reset mid-PLAY while frightened
    step(0, 1, 1, 0, 0, 0, 0, pk(1, 3, 16'h0000, 0, 0));
    step(0, 1, 0, 0, 0, 1, 0, pk(1, 3, 16'h0050, 1, 0));
    step(0, 0, 0, 0, 1, 0, 0, pk(0, 3, 16'h0000, 0, 0));
    step(0, 1, 0, 0, 0, 0, 0, pk(0, 3, 16'h0000, 0, 0));
    // second instance: BCD carries and saturation at 9999
    step(1, 1, 1, 0, 0, 0, 0, pk(1, 3, 16'h0000, 0, 0));
    step(1, 1, 0, 0, 0, 1, 0, pk(1, 3, 16'h0050, 1, 0));
    step(1, 1, 0, 0, 1, 0, 0, pk(1, 3, 16'h0095, 1, 0));
    step(1, 1, 0, 0, 1, 1, 0, pk(1, 3, 16'h0190, 1, 0));
    step(1, 1, 0, 0, 0, 0, 1, pk(1, 3, 16'h9190, 1, 0));
    step(1, 1, 0, 0, 0, 0, 1, pk(1, 3, 16'h9999, 1, 0));
    step(1, 1, 0, 0, 1, 0, 0, pk(1, 3, 16'h9999, 1, 0));
    @(negedge clk);
    {b_start, b_ack, b_pe, b_pw, b_gh} = 5'b0;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
# score_keeper

Game-state and scoring stage between `pacman_movement` (upstream event source) and the seven-segment scan logic in `pacman_top` (downstream consumer). Counts pellets, power pellets and ghost captures into a 4-digit saturating BCD score, tracks lives, the frightened-mode timer and remaining pellets, and runs the INIT/PLAY/WIN/LOSE game FSM. `score` drives SSD7..SSD4 nibble-for-nibble with no further conversion.

## Interface
Parameters:
- `PELLET_PTS`, 16'h0010, BCD points per ordinary pellet
- `POWER_PTS`, 16'h0050, BCD points per power pellet
- `GHOST_PTS`, 16'h0200, BCD points per ghost eaten while frightened
- `PELLET_TOTAL`, 240, pellets + power pellets on the map; all eaten = win
- `LIVES_INIT`, 3, lives at game start (1..3)
- `FRIGHT_CYCLES`, 500_000_000, frightened-mode length in `clk` cycles (32-bit counter)

Ports:
- `clk` in 1: system clock (`sys_clk`, 100 MHz)
- `reset` in 1: synchronous, active-low reset
- `start` in 1: single-cycle pulse (debounced BtnC SCEN); INIT -> PLAY
- `ack` in 1: single-cycle pulse; WIN/LOSE -> INIT
- `pelletEaten` in 1: single-cycle pulse per ordinary pellet
- `powerEaten` in 1: single-cycle pulse per power pellet
- `ghostHit` in 1: single-cycle pulse, Pac-Man overlaps a ghost
- `score` out 16: 4-digit BCD, [15:12] thousands … [3:0] units
- `lives` out 2: remaining lives
- `frightened` out 1: high while frightened timer nonzero
- `respawn` out 1: single-cycle pulse after a life is lost (to movement/ghost modules)
- `win` out 1: high in WIN
- `lose` out 1: high in LOSE
- `state` out 2: INIT=00, PLAY=01, WIN=10, LOSE=11

## Operation
- Reset (`reset`=0 at a `clk` edge): state INIT, score 0x0000, lives `LIVES_INIT`, pellets-left `PELLET_TOTAL`, fright timer 0, frightened/respawn/win/lose 0. Overrides every other input, mid-game included.
- INIT: all event inputs ignored. `start` -> PLAY; on that edge score, lives, pellets-left, fright timer reload to reset values.
- PLAY, per cycle, all events evaluated together:
  - addend = BCD sum of PELLET_PTS if `pelletEaten`, POWER_PTS if `powerEaten`, GHOST_PTS if `ghostHit` and frightened; score += addend in BCD with digit carries; result > 9999 saturates at 0x9999.
  - pellets-left -= (`pelletEaten` + `powerEaten`), floored at 0.
  - `powerEaten`: fright timer loads FRIGHT_CYCLES (reload if already running); otherwise a nonzero timer decrements by 1.
  - `ghostHit` and not frightened: lives -= 1; if result is 0 -> LOSE, else `respawn` pulses and fright timer clears.
  - pellets-left reaching 0 -> WIN. Takes priority over a same-cycle non-frightened `ghostHit`: hit ignored, lives unchanged, no `respawn`.
  - `start` ignored in PLAY.
- WIN / LOSE: score and lives frozen, fright timer cleared, events ignored; `ack` -> INIT (score held until next `start`). `start` ignored.
- `ack` outside WIN/LOSE ignored.
- `frightened` is decoded from the registered timer (`timer != 0`).

## Timing
- All outputs registered; event pulse at edge N -> `score`/`lives`/`frightened`/`state` updated after edge N (visible in cycle N+1).
- `respawn` high for exactly one cycle, same cycle as decremented `lives`.
- `win`/`lose` assert in the same cycle `state` changes.
- Back-to-back pulses on consecutive cycles each counted; no event lost.
- Frightened lasts exactly FRIGHT_CYCLES cycles after the loading edge.
- Score saturation and pellets-left floor never wrap.

## Test plan
Bench parameters: PELLET_TOTAL=4, FRIGHT_CYCLES=8, LIVES_INIT=3.
- Reset low 2 cycles, then `start` -> state 01, score 0x0000, lives 3; three `pelletEaten` pulses on consecutive cycles -> score 0x0030.
- `powerEaten` -> score +0x0050, `frightened`=1 for exactly 8 cycles; `ghostHit` inside that window -> score +0x0200, lives unchanged, no `respawn`.
- Three non-frightened `ghostHit` -> lives 2, 1 with `respawn` pulses, then `lose`=1, state 11, lives 0; `ack` -> state 00.
- 4th pellet and non-frightened `ghostHit` in same cycle -> `win`=1, state 10, lives unchanged, no `respawn`.
- Score preloaded near max (e.g. 0x9990) + `powerEaten` -> 0x9999; `pelletEaten`+`powerEaten` together from 0x0095 -> 0x0155.
- `reset` low mid-PLAY with frightened active -> next cycle all outputs at reset values, state 00.
